// File: rtl/reg_file_debug_port_if.sv
// Debug-port bus: command, register-file access, dump stream and load stream.
// The debug initiator is the master; the register file and host side form the slave.
interface reg_file_debug_port_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
) ();
    logic              cmd_valid;
    logic              cmd_op;
    logic              cmd_ready;
    logic              hold_req;
    logic [ADDR_W-1:0] rf_read_addr;
    logic [DATA_W-1:0] rf_read_data;
    logic              rf_write_en;
    logic [ADDR_W-1:0] rf_write_dest;
    logic [DATA_W-1:0] rf_write_data;
    logic              dump_valid;
    logic              dump_ready;
    logic [DATA_W-1:0] dump_data;
    logic [ADDR_W-1:0] dump_addr;
    logic              dump_last;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              done;

    modport master (
        input  cmd_valid, cmd_op, rf_read_data, dump_ready, load_valid, load_data,
        output cmd_ready, hold_req, rf_read_addr, rf_write_en, rf_write_dest, rf_write_data,
               dump_valid, dump_data, dump_addr, dump_last, load_ready, done
    );

    modport slave (
        output cmd_valid, cmd_op, rf_read_data, dump_ready, load_valid, load_data,
        input  cmd_ready, hold_req, rf_read_addr, rf_write_en, rf_write_dest, rf_write_data,
               dump_valid, dump_data, dump_addr, dump_last, load_ready, done
    );
endinterface

// File: rtl/reg_file_debug_port.sv
// Debug initiator for the register file: dumps FIRST_REG..LAST_REG to a stream,
// or loads a stream of words into them, holding off the core while busy.
module reg_file_debug_port #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned FIRST_REG = 1,
    parameter int unsigned LAST_REG  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_file_debug_port_if.master dbg
);
    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DUMP_RD  = 2'd1,
        DUMP_OUT = 2'd2,
        LOAD     = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              dump_valid;
    logic [DATA_W-1:0] dump_data;
    logic [ADDR_W-1:0] dump_addr;
    logic              dump_last;
    logic              rf_write_en;
    logic [ADDR_W-1:0] rf_write_dest;
    logic [DATA_W-1:0] rf_write_data;
    logic              done;

    // Command sequencer; every output it drives is registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= FIRST_A;
            dump_valid    <= 1'b0;
            dump_data     <= '0;
            dump_addr     <= '0;
            dump_last     <= 1'b0;
            rf_write_en   <= 1'b0;
            rf_write_dest <= '0;
            rf_write_data <= '0;
            done          <= 1'b0;
        end else begin
            done        <= 1'b0;
            rf_write_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (dbg.cmd_valid) begin
                        ptr   <= FIRST_A;
                        state <= dbg.cmd_op ? LOAD : DUMP_RD;
                    end
                end
                DUMP_RD: begin
                    dump_data  <= dbg.rf_read_data;
                    dump_addr  <= ptr;
                    dump_last  <= (ptr == LAST_A);
                    dump_valid <= 1'b1;
                    state      <= DUMP_OUT;
                end
                DUMP_OUT: begin
                    if (dbg.dump_ready) begin
                        dump_valid <= 1'b0;
                        if (dump_last) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            ptr   <= ptr + ADDR_W'(1);
                            state <= DUMP_RD;
                        end
                    end
                end
                LOAD: begin
                    if (dbg.load_valid) begin
                        rf_write_en   <= 1'b1;
                        rf_write_dest <= ptr;
                        rf_write_data <= dbg.load_data;
                        // ptr parks on LAST_REG; the next command reloads it
                        if (ptr == LAST_A) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            ptr <= ptr + ADDR_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake readies and the read address decode straight from state.
    assign dbg.cmd_ready     = (state == IDLE);
    assign dbg.load_ready    = (state == LOAD);
    assign dbg.rf_read_addr  = (state == DUMP_RD) ? ptr : '0;
    assign dbg.hold_req      = (state != IDLE) | rf_write_en;

    assign dbg.dump_valid    = dump_valid;
    assign dbg.dump_data     = dump_data;
    assign dbg.dump_addr     = dump_addr;
    assign dbg.dump_last     = dump_last;
    assign dbg.rf_write_en   = rf_write_en;
    assign dbg.rf_write_dest = rf_write_dest;
    assign dbg.rf_write_data = rf_write_data;
    assign dbg.done          = done;
endmodule

// File: tb/tb_reg_file_debug_port.sv
// Directed bench for reg_file_debug_port with a behavioural 8x16 register file.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_reg_file_debug_port;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload_en = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;

    logic [15:0] rf      [8];
    logic [15:0] exp_mem [8];

    reg_file_debug_port_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    reg_file_debug_port #(
        .DATA_W(16), .ADDR_W(3), .FIRST_REG(1), .LAST_REG(7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dbg(bus)
    );

    always #5 clk = ~clk;

    // Register file model: r0 stays zero, reset clears everything.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
        end else if (preload_en) begin
            for (int i = 0; i < 8; i++) rf[i] <= 16'(16'h1111 * i);
        end else if (bus.rf_write_en && bus.rf_write_dest != 3'd0) begin
            rf[bus.rf_write_dest] <= bus.rf_write_data;
        end
    end

    assign bus.rf_read_data = rf[bus.rf_read_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; issues a dump and checks every beat against exp_mem.
    task automatic do_dump(input string tag, input int stall_beat, input int stall_len,
                           input int poke_beat);
        int cyc;
        check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 1);
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = 1'b0;
        bus.dump_ready = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check({tag, "_hold"}, 32'(bus.hold_req), 1);
        check({tag, "_early_valid"}, 32'(bus.dump_valid), 0);
        for (int b = 1; b <= 7; b++) begin
            cyc = 0;
            while (!bus.dump_valid && cyc < 8) begin
                @(negedge clk);
                cyc++;
            end
            check({tag, "_gap"}, 32'(cyc), 1);
            check({tag, "_data"}, 32'(bus.dump_data), 32'(exp_mem[b]));
            check({tag, "_addr"}, 32'(bus.dump_addr), 32'(b));
            check({tag, "_last"}, 32'(bus.dump_last), (b == 7) ? 1 : 0);
            check({tag, "_wr_en"}, 32'(bus.rf_write_en), 0);
            if (b == poke_beat) begin
                check({tag, "_busy_ready"}, 32'(bus.cmd_ready), 0);
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = 1'b1;
            end
            if (b == stall_beat) begin
                bus.dump_ready = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    check({tag, "_stall_valid"}, 32'(bus.dump_valid), 1);
                    check({tag, "_stall_data"}, 32'(bus.dump_data), 32'(exp_mem[b]));
                    check({tag, "_stall_addr"}, 32'(bus.dump_addr), 32'(b));
                end
                bus.dump_ready = 1'b1;
            end
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            check({tag, "_valid_drop"}, 32'(bus.dump_valid), 0);
            check({tag, "_done"}, 32'(bus.done), (b == 7) ? 1 : 0);
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus.done), 0);
        check({tag, "_idle_ready"}, 32'(bus.cmd_ready), 1);
        check({tag, "_idle_hold"}, 32'(bus.hold_req), 0);
    endtask

    // Called on a falling edge; loads n words base+k with a fixed gap pattern.
    task automatic do_load(input string tag, input logic [15:0] base, input int n);
        int gaps [7] = '{0, 2, 1, 0, 3, 0, 1};
        check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check({tag, "_load_ready"}, 32'(bus.load_ready), 1);
        for (int k = 1; k <= n; k++) begin
            bus.load_valid = 1'b0;
            repeat (gaps[k-1]) begin
                @(negedge clk);
                check({tag, "_gap_wr"}, 32'(bus.rf_write_en), 0);
            end
            bus.load_valid = 1'b1;
            bus.load_data  = base + 16'(k);
            @(negedge clk);
            check({tag, "_wr_en"}, 32'(bus.rf_write_en), 1);
            check({tag, "_dest"}, 32'(bus.rf_write_dest), 32'(k));
            check({tag, "_wdata"}, 32'(bus.rf_write_data), 32'(base + 16'(k)));
            check({tag, "_done"}, 32'(bus.done), (k == 7) ? 1 : 0);
            check({tag, "_ready_after"}, 32'(bus.load_ready), (k == 7) ? 0 : 1);
        end
        bus.load_valid = 1'b0;
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 1'b0;
        bus.dump_ready = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        check("rst_hold", 32'(bus.hold_req), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_dump_valid", 32'(bus.dump_valid), 0);
        check("rst_wr_en", 32'(bus.rf_write_en), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_load_ready", 32'(bus.load_ready), 0);
        check("rst_read_addr", 32'(bus.rf_read_addr), 0);

        preload_en = 1'b1;
        @(negedge clk);
        preload_en = 1'b0;
        for (int i = 0; i < 8; i++) exp_mem[i] = 16'(16'h1111 * i);

        do_dump("d1", 0, 0, 0);
        do_dump("d2", 3, 5, 0);
        do_dump("d4", 0, 0, 4);
        check("poke_not_queued", 32'(bus.load_ready), 0);
        do_dump("d4b", 0, 0, 0);

        do_load("ld", 16'hA000, 7);
        for (int i = 1; i < 8; i++) exp_mem[i] = 16'hA000 + 16'(i);
        do_dump("d3", 0, 0, 0);

        do_load("ldr", 16'hB000, 3);
        #2 rst = 1'b1;
        #1;
        check("arst_wr_en", 32'(bus.rf_write_en), 0);
        check("arst_hold", 32'(bus.hold_req), 0);
        check("arst_load_ready", 32'(bus.load_ready), 0);
        check("arst_done", 32'(bus.done), 0);
        check("arst_cmd_ready", 32'(bus.cmd_ready), 1);
        check("arst_wdata", 32'(bus.rf_write_data), 0);
        @(negedge clk);
        check("arst_no_done", 32'(bus.done), 0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) exp_mem[i] = 16'h0000;
        do_dump("d5", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
